// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multicycle RISC-V control unit: the controller
// state enumeration, the four supported opcodes and the encodings used on the
// datapath mux selects (ALUOp, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc).
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_BEQ      = 4'd8
   } state_e;

   // Supported opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   // ALUOp: operation class handed to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ResultSrc: value driven onto the result bus
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA: first ALU operand
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALUSrcB: second ALU operand
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ImmSrc: immediate format
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   // Immediate format is a pure function of the opcode, independent of state.
   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_STORE: imm_sel = IMM_S;
         OP_BEQ:   imm_sel = IMM_B;
         default:  imm_sel = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// -----------------------------------------------------------------------------
// ctrl_output_decode
// Purely combinational output decoder for the multicycle control FSM.
// Ports:
//   i_state      - current controller state
//   i_opcode     - instr[6:0], used for ImmSrc and illegal-opcode detection
//   i_zero       - ALU zero flag, qualifies PCWrite in BEQ
//   i_mem_ready  - memory handshake, qualifies IRWrite/PCWrite in FETCH
//   o_*          - datapath enables, mux selects and the illegal_op pulse
// -----------------------------------------------------------------------------
module ctrl_output_decode
   import riscv_ctrl_pkg::*;
(
   input  state_e     i_state,
   input  logic [6:0] i_opcode,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic       o_pc_write,
   output logic       o_ir_write,
   output logic       o_reg_write,
   output logic       o_mem_write,
   output logic       o_adr_src,
   output logic       o_illegal_op,
   output logic [1:0] o_result_src,
   output logic [1:0] o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_imm_src,
   output logic [1:0] o_alu_op
);

   logic w_supported_op;

   assign w_supported_op = (i_opcode == OP_LOAD)  || (i_opcode == OP_STORE) ||
                           (i_opcode == OP_RTYPE) || (i_opcode == OP_BEQ);

   assign o_imm_src = imm_sel(i_opcode);

   always_comb begin
      // NOTE: every output gets a default before the case so no path through
      // the block leaves a signal unassigned, which would infer a latch.
      o_pc_write   = 1'b0;
      o_ir_write   = 1'b0;
      o_reg_write  = 1'b0;
      o_mem_write  = 1'b0;
      o_adr_src    = 1'b0;
      o_illegal_op = 1'b0;
      o_result_src = RES_ALUOUT;
      o_alu_src_a  = SRCA_PC;
      o_alu_src_b  = SRCB_RS2;
      o_alu_op     = ALUOP_ADD;

      case (i_state)
         S_FETCH: begin
            // PC <= PC+4 travels on the ALU result bus while memory fetches;
            // the instruction and new PC are only committed once memory is done.
            o_alu_src_b  = SRCB_FOUR;
            o_result_src = RES_ALURESULT;
            o_ir_write   = i_mem_ready;
            o_pc_write   = i_mem_ready;
         end
         S_DECODE: begin
            // Branch target (old PC + imm) is precomputed while decoding.
            o_alu_src_a  = SRCA_OLDPC;
            o_alu_src_b  = SRCB_IMM;
            o_illegal_op = ~w_supported_op;
         end
         S_MEMADR: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            o_adr_src = 1'b1;
         end
         S_MEMWB: begin
            o_result_src = RES_DATA;
            o_reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            // Write strobe stays up for the whole access, not just the last cycle.
            o_adr_src   = 1'b1;
            o_mem_write = 1'b1;
         end
         S_EXECR: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_reg_write = 1'b1;
         end
         S_BEQ: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_op    = ALUOP_SUB;
            o_pc_write  = i_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
// Main controller for a multicycle RISC-V datapath supporting lw, sw, R-type
// and beq. Holds the state register and next-state logic; output decoding is
// delegated to ctrl_output_decode.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   opcode       - instr[6:0] from the instruction register
//   zero         - ALU zero flag
//   mem_ready    - memory completes the current access this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc - enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp   - mux selects / ALU class
//   illegal_op   - one-cycle pulse when DECODE sees an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_control_fsm
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUOp,
   output logic       illegal_op
);

   state_e r_state;
   state_e w_next_state;
   state_e w_dec_state;
   logic   w_dec_ready;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples its inputs from the same pre-edge values.
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
               OP_RTYPE:          w_next_state = S_EXECR;
               OP_BEQ:            w_next_state = S_BEQ;
               default:           w_next_state = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
         S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
         S_MEMWB:    w_next_state = S_FETCH;
         S_EXECR:    w_next_state = S_ALUWB;
         S_ALUWB:    w_next_state = S_FETCH;
         S_BEQ:      w_next_state = S_FETCH;
         default:    w_next_state = S_FETCH;
      endcase
   end

   // While reset is high the outputs look like an idle FETCH: presenting FETCH
   // to the decoder with mem_ready masked keeps every write enable and
   // illegal_op low, whatever state the register currently holds.
   assign w_dec_state = reset ? S_FETCH : r_state;
   assign w_dec_ready = mem_ready & ~reset;

   ctrl_output_decode u_decode (
      .i_state      (w_dec_state),
      .i_opcode     (opcode),
      .i_zero       (zero),
      .i_mem_ready  (w_dec_ready),
      .o_pc_write   (PCWrite),
      .o_ir_write   (IRWrite),
      .o_reg_write  (RegWrite),
      .o_mem_write  (MemWrite),
      .o_adr_src    (AdrSrc),
      .o_illegal_op (illegal_op),
      .o_result_src (ResultSrc),
      .o_alu_src_a  (ALUSrcA),
      .o_alu_src_b  (ALUSrcB),
      .o_imm_src    (ImmSrc),
      .o_alu_op     (ALUOp)
   );

endmodule
